nanojeff_mem: RTL

NANOJEFF_MEM -- requirements
Module: nanojeff_mem

---
 rtl/nanojeff_mem.sv | 100 ++++++++++
 1 files changed

// File: rtl/nanojeff_mem.sv
// Boot memory for the nanojeff CPU: streams a program in from a loader, then serves
// instruction/data reads and CPU writes, with optional write protection of low words.
module nanojeff_mem #(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int RD_REG   = 0,
  parameter int PROT_TOP = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          cpu_reset,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] inst,
  input  logic [AW-1:0] daddr,
  output logic [DW-1:0] data,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic          prot_err,
  output logic [AW:0]   ld_count
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] mem [2**AW];
  logic          ld_acc;
  logic          cpu_wr;
  logic          prot_hit;

  assign ld_ready  = (state == S_LOAD);
  assign cpu_reset = (state != S_RUN);
  assign ld_acc    = ld_valid && ld_ready;
  assign cpu_wr    = wen && (state == S_RUN);

  generate
    if (PROT_TOP == 0) begin : g_noprot
      assign prot_hit = 1'b0;
    end else begin : g_prot
      assign prot_hit = (32'(waddr) < 32'(PROT_TOP));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_LOAD;
      ld_count <= '0;
      prot_err <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (ld_acc) begin
            ld_count <= ld_count + (AW+1)'(1);
            // Accepting the top address ends the load even without ld_last.
            if (ld_last || (&ld_count[AW-1:0])) state <= S_HOLD;
          end
        end
        S_HOLD:  state <= S_RUN;
        S_RUN: begin
          if (cpu_wr && prot_hit) prot_err <= 1'b1;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Contents survive reset; reset only blocks writes on its own edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ld_acc)
        mem[ld_count[AW-1:0]] <= ld_data;
      else if (cpu_wr && !prot_hit)
        mem[waddr] <= wdata;
    end
  end

  generate
    if (RD_REG == 0) begin : g_comb_rd
      assign inst = mem[iaddr];
      assign data = mem[daddr];
    end else begin : g_reg_rd
      always_ff @(posedge clk) begin
        if (reset) begin
          inst <= '0;
          data <= '0;
        end else begin
          inst <= mem[iaddr];
          data <= mem[daddr];
        end
      end
    end
  endgenerate

endmodule
